// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_pkg
// Purpose  : Shared command encoding and default geometry for the memory
//            query/answer protocol (sequencer <-> responder).
// Revision : 1.0 - initial release
// ============================================================================
package memory_pkg;

   // Default geometry: 8192 blocks of 64 bits, 4-bit transaction tags
   localparam int DEF_IDX_W = 13;
   localparam int DEF_BLK_W = 64;
   localparam int DEF_TAG_W = 4;

   // Request command; encoding 3 is unused and behaves as NONE
   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_LOAD  = 2'd1,
      CMD_STORE = 2'd2
   } cmd_e;

endpackage
`default_nettype wire

// File: rtl/mem_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_lat_pipe
// Purpose  : Fixed-latency delay line carrying {valid, tag, data} for each
//            accepted transaction until its answer cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lat_pipe #(
   parameter int LATENCY = 4,
   parameter int TAG_W   = 4,
   parameter int BLK_W   = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic [BLK_W-1:0] blk_i,
   output logic             valid_o,
   output logic [TAG_W-1:0] tag_o,
   output logic [BLK_W-1:0] blk_o
);

   logic [LATENCY-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q [LATENCY];
   logic [BLK_W-1:0]   blk_q [LATENCY];

   // Shift every stage forward each cycle; reset flushes all in-flight entries
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            tag_q[s] <= '0;
            blk_q[s] <= '0;
         end
      end else begin
         valid_q[0] <= valid_i;
         tag_q[0]   <= tag_i;
         blk_q[0]   <= blk_i;
         for (int s = 1; s < LATENCY; s++) begin
            valid_q[s] <= valid_q[s-1];
            tag_q[s]   <= tag_q[s-1];
            blk_q[s]   <= blk_q[s-1];
         end
      end
   end

   // Idle slots are loaded with zero tag/data, so the last stage can be
   // presented directly as the answer without extra gating
   assign valid_o = valid_q[LATENCY-1];
   assign tag_o   = tag_q[LATENCY-1];
   assign blk_o   = blk_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp
// Purpose  : Responder end of the memory query/answer protocol. Accepts
//            LOAD/STORE requests with a same-cycle tag, answers each one a
//            fixed LATENCY cycles later, and bounds in-flight transactions.
// Revision : 1.0 - initial release
// ============================================================================
module mem_resp
   import memory_pkg::*;
#(
   parameter int IDX_W   = DEF_IDX_W,
   parameter int BLK_W   = DEF_BLK_W,
   parameter int TAG_W   = DEF_TAG_W,
   parameter int LATENCY = 4,
   parameter int MAX_OUT = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       qry_cmd,
   input  logic [IDX_W-1:0] qry_idx,
   input  logic [BLK_W-1:0] qry_blk,
   output logic [TAG_W-1:0] ack,
   output logic [TAG_W-1:0] ans_tag,
   output logic [BLK_W-1:0] ans_blk
);

   localparam int              DEPTH   = 1 << IDX_W;
   localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
   localparam logic [TAG_W-1:0] TAG_MAX = {TAG_W{1'b1}};

   logic [BLK_W-1:0] mem_q [DEPTH];
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [TAG_W-1:0] out_q, out_d;

   logic             is_load;
   logic             is_store;
   logic             retiring;
   logic [TAG_W-1:0] out_eff;
   logic             accept;
   logic [BLK_W-1:0] pipe_blk;

   // A slot freed by this cycle's answer may be reused in the same cycle
   always_comb begin
      is_load  = (qry_cmd == CMD_LOAD);
      is_store = (qry_cmd == CMD_STORE);
      out_eff  = out_q - TAG_W'(retiring);
      accept   = (is_load || is_store) && !reset && (out_eff < TAG_W'(MAX_OUT));
      ack      = accept ? tag_q : '0;
      // Read happens before the accepting edge's write, so a store in the
      // previous cycle is already visible here; stores answer with zero data
      pipe_blk = (accept && is_load) ? mem_q[qry_idx] : '0;
   end

   // Next tag (wraps past zero) and outstanding count
   always_comb begin
      tag_d = tag_q;
      if (accept) begin
         tag_d = (tag_q == TAG_MAX) ? TAG_ONE : tag_q + TAG_ONE;
      end
      case ({accept, retiring})
         2'b10:   out_d = out_q + TAG_ONE;
         2'b01:   out_d = out_q - TAG_ONE;
         default: out_d = out_q;
      endcase
   end

   // Control state: tag counter and in-flight count
   always_ff @(posedge clock) begin
      if (reset) begin
         tag_q <= TAG_ONE;
         out_q <= '0;
      end else begin
         tag_q <= tag_d;
         out_q <= out_d;
      end
   end

   // Block storage; deliberately not reset so contents survive a reset
   always_ff @(posedge clock) begin
      if (accept && is_store) begin
         mem_q[qry_idx] <= qry_blk;
      end
   end

   mem_lat_pipe #(
      .LATENCY (LATENCY),
      .TAG_W   (TAG_W),
      .BLK_W   (BLK_W)
   ) u_lat_pipe (
      .clk_i   (clock),
      .rst_i   (reset),
      .valid_i (accept),
      .tag_i   (ack),
      .blk_i   (pipe_blk),
      .valid_o (retiring),
      .tag_o   (ans_tag),
      .blk_o   (ans_blk)
   );

endmodule
`default_nettype wire

// File: tb/tb_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_resp
// Purpose  : Self-checking bench for mem_resp: queue-based reference model,
//            directed scenarios with literal expectations, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_resp;

   localparam int LAT  = 4;
   localparam int MAXO = 3;

   logic        clk;
   logic        rst_r;
   logic [1:0]  cmd_r;
   logic [12:0] idx_r;
   logic [63:0] blk_r;
   logic [3:0]  ack;
   logic [3:0]  ans_tag;
   logic [63:0] ans_blk;

   int errors = 0;
   int checks = 0;

   mem_resp #(
      .IDX_W   (13),
      .BLK_W   (64),
      .TAG_W   (4),
      .LATENCY (LAT),
      .MAX_OUT (MAXO)
   ) dut (
      .clock   (clk),
      .reset   (rst_r),
      .qry_cmd (cmd_r),
      .qry_idx (idx_r),
      .qry_blk (blk_r),
      .ack     (ack),
      .ans_tag (ans_tag),
      .ans_blk (ans_blk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          tag;
      logic [63:0] blk;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [63:0] mem_m[int];
   int          tag_m = 1;
   int          cyc   = 0;
   bit          ret_m = 0;
   bit          acc_m = 0;

   // Expected outputs for the current cycle, compared every cycle
   always @(negedge clk) begin
      logic [63:0] e_blk;
      int          e_tag;
      int          e_ack;
      ret_m = (pend.size() > 0) && (pend[0].due == cyc);
      e_tag = ret_m ? pend[0].tag : 0;
      e_blk = ret_m ? pend[0].blk : 64'd0;
      acc_m = ((cmd_r == 2'd1) || (cmd_r == 2'd2)) && !rst_r &&
              ((pend.size() - (ret_m ? 1 : 0)) < MAXO);
      e_ack = acc_m ? tag_m : 0;
      chk("ack", 64'(ack), 64'(e_ack));
      chk("ans_tag", 64'(ans_tag), 64'(e_tag));
      chk("ans_blk", ans_blk, e_blk);
   end

   // Model state update at the clock edge
   always @(posedge clk) begin
      pend_t e;
      if (rst_r) begin
         pend.delete();
         tag_m = 1;
      end else begin
         if (ret_m) void'(pend.pop_front());
         if (acc_m) begin
            e.tag = tag_m;
            e.blk = 64'd0;
            if (cmd_r == 2'd1 && mem_m.exists(int'(idx_r))) e.blk = mem_m[int'(idx_r)];
            if (cmd_r == 2'd2) mem_m[int'(idx_r)] = blk_r;
            e.due = cyc + LAT;
            pend.push_back(e);
            tag_m = (tag_m == 15) ? 1 : tag_m + 1;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic r, input logic [1:0] c, input logic [12:0] i,
                       input logic [63:0] b);
      @(posedge clk);
      #1;
      rst_r = r;
      cmd_r = c;
      idx_r = i;
      blk_r = b;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 2'd0, 13'd0, 64'd0);
   endtask

   task automatic do_reset();
      step(1'b1, 2'd0, 13'd0, 64'd0);
      step(1'b1, 2'd0, 13'd0, 64'd0);
   endtask

   initial begin
      int a33[4];
      int k;
      int tries;
      logic [1:0] c;
      logic [12:0] ri;
      a33 = '{1, 2, 3, 0};
      rst_r = 1'b1;
      cmd_r = 2'd0;
      idx_r = '0;
      blk_r = '0;

      // Store answers with zero data after LATENCY cycles
      do_reset();
      step(1'b0, 2'd2, 13'd5, 64'hDEAD_BEEF_0000_0001);
      chk("r031_ack", 64'(ack), 64'd1);
      repeat (3) idle();
      idle();
      chk("r031_ans_tag", 64'(ans_tag), 64'd1);
      chk("r031_ans_blk", ans_blk, 64'd0);
      repeat (4) idle();

      // Load right after store sees the new data
      do_reset();
      step(1'b0, 2'd2, 13'd5, 64'hA5);
      chk("r032_ack0", 64'(ack), 64'd1);
      step(1'b0, 2'd1, 13'd5, 64'd0);
      chk("r032_ack1", 64'(ack), 64'd2);
      repeat (3) idle();
      idle();
      chk("r032_ans_tag", 64'(ans_tag), 64'd2);
      chk("r032_ans_blk", ans_blk, 64'hA5);
      repeat (4) idle();

      // In-flight limit and same-cycle slot reuse
      do_reset();
      for (int n = 0; n < 4; n++) begin
         step(1'b0, 2'd1, 13'd5, 64'd0);
         chk("r033_ack", 64'(ack), 64'(a33[n]));
      end
      step(1'b0, 2'd1, 13'd5, 64'd0);
      chk("r033_ack4", 64'(ack), 64'd4);
      chk("r033_ans_tag", 64'(ans_tag), 64'd1);
      chk("r033_ans_blk", ans_blk, 64'hA5);
      repeat (8) idle();

      // Tag wrap 15 -> 1 over 19 accepted requests
      do_reset();
      k = 0;
      tries = 0;
      while (k < 19 && tries < 200) begin
         step(1'b0, 2'd2, 13'(100 + k), 64'(k));
         tries++;
         if (ack != 4'd0) begin
            chk("r034_ack", 64'(ack), 64'((k % 15) + 1));
            k++;
         end
      end
      if (k < 19) begin
         checks++;
         errors++;
         $display("FAIL r034_timeout: accepted %0d required 19", k);
      end
      repeat (8) idle();

      // Reset with loads in flight drops them
      do_reset();
      step(1'b0, 2'd1, 13'd5, 64'd0);
      step(1'b0, 2'd1, 13'd5, 64'd0);
      step(1'b1, 2'd1, 13'd5, 64'd0);
      chk("r035_ack_rst", 64'(ack), 64'd0);
      for (int n = 0; n < 8; n++) begin
         idle();
         chk("r035_no_ans", 64'(ans_tag), 64'd0);
      end
      step(1'b0, 2'd1, 13'd5, 64'd0);
      chk("r035_ack_after", 64'(ack), 64'd1);
      repeat (8) idle();

      // Command 3 is ignored and leaves storage untouched
      do_reset();
      for (int n = 0; n < 10; n++) begin
         step(1'b0, 2'd3, 13'd5, {$urandom, $urandom});
         chk("r036_ack", 64'(ack), 64'd0);
         chk("r036_ans_tag", 64'(ans_tag), 64'd0);
      end
      step(1'b0, 2'd1, 13'd5, 64'd0);
      chk("r036_load_ack", 64'(ack), 64'd1);
      repeat (3) idle();
      idle();
      chk("r036_ans_blk", ans_blk, 64'hA5);
      repeat (4) idle();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         c  = 2'($urandom % 4);
         ri = 13'($urandom % 16);
         if (c == 2'd1 && !mem_m.exists(int'(ri))) c = 2'd2;
         step(($urandom % 100) < 2, c, ri, {$urandom, $urandom});
      end
      repeat (10) idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter IDX_W, 13, block index width (8192 blocks).
REQ-002 Parameter BLK_W, 64, data block width in bits.
REQ-003 Parameter TAG_W, 4, transaction tag width; tag 0 means "none/rejected".
REQ-004 Parameter LATENCY, 4, cycles from accept edge to answer; legal range 1..8.
REQ-005 Parameter MAX_OUT, 3, maximum in-flight transactions; legal range 1..2^TAG_W-2.
REQ-006 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port qry_cmd  input  2  request command: NONE=0, LOAD=1, STORE=2, 3 treated as NONE.
REQ-009 Port qry_idx  input  IDX_W  block index of the request.
REQ-010 Port qry_blk  input  BLK_W  store data; ignored for LOAD.
REQ-011 Port ack  output  TAG_W  same-cycle acceptance: allocated tag, or 0 when rejected or idle.
REQ-012 Port ans_tag  output  TAG_W  tag of the transaction completing this cycle, 0 when none.
REQ-013 Port ans_blk  output  BLK_W  load data for ans_tag; 0 for stores and when ans_tag=0.

Function
REQ-014 Block SHALL be the responder end of the memory query/answer protocol driven by the memory sequencer.
REQ-015 Storage SHALL be 2^IDX_W blocks of BLK_W bits.
REQ-016 Request SHALL be accepted iff qry_cmd is LOAD/STORE, reset low, and (outstanding - retiring_this_cycle) < MAX_OUT.
REQ-017 ack SHALL be combinational from inputs and state; nonzero exactly in accepted cycles.
REQ-018 Tag counter SHALL start at 1, advance by 1 per accept, wrap 2^TAG_W-1 -> 1, never issue 0.
REQ-019 STORE SHALL write qry_blk to qry_idx at the accepting edge.
REQ-020 LOAD SHALL read qry_idx at the accepting edge, so a LOAD accepted the cycle after a STORE to the same index returns the new data.
REQ-021 Every accepted request (LOAD or STORE) SHALL be answered exactly once, at the cycle LATENCY cycles after its accept cycle; ans_tag/ans_blk registered.
REQ-022 At most one accept per cycle, so at most one answer per cycle; answers in accept order.
REQ-023 Outstanding count SHALL increment on accept and decrement on answer; simultaneous accept and answer leave it unchanged.
REQ-024 Rejected request SHALL cause no state change; requester retries.

Reset
REQ-025 While reset is high: ack=0; at the edge, pipeline valids cleared, outstanding=0, tag counter=1.
REQ-026 Cycle after reset: ans_tag=0, ans_blk=0.
REQ-027 Reset mid-operation SHALL drop all in-flight transactions with no answers; storage contents not reset.

Structure
REQ-028 Shared package memory_pkg SHALL hold the cmd enum (NONE/LOAD/STORE) and default IDX_W/BLK_W/TAG_W constants.
REQ-029 Latency delay line SHALL be one sub-module mem_lat_pipe (LATENCY stages of {valid, tag, data}).
REQ-030 Array, accept logic, tag counter and outstanding counter SHALL live in mem_resp.

Verification
REQ-031 After reset, STORE idx=5 blk=0xDEAD_BEEF_0000_0001 at cycle 0 -> ack=1; cycle 4 ans_tag=1, ans_blk=0.
REQ-032 STORE idx=5 blk=0xA5 at cycle 0, LOAD idx=5 at cycle 1 -> acks 1,2; cycle 5 ans_tag=2, ans_blk=0xA5.
REQ-033 LOADs on cycles 0,1,2,3 with MAX_OUT=3, LATENCY=4 -> acks 1,2,3,0; cycle 4 ans_tag=1, LOAD on cycle 4 accepted with ack=4.
REQ-034 19 back-to-back accepted requests -> acks 1..15, then 1..4 (wrap skips 0); answers in the same tag order.
REQ-035 Reset asserted at cycle 2 with 2 loads in flight -> ack=0 during reset, no nonzero ans_tag afterward; next accept gets ack=1.
REQ-036 qry_cmd=3 for 10 cycles -> ack=0, ans_tag=0 throughout, storage unchanged.
